adv_video_timing: RTL

//  Pixel-clock video timing generator and pattern source feeding adv_ddr. Produces de/hsync/vsync
//  and 24-bpp RGB {R[23:16],G[15:8],B[7:0]}, either passed through from an upstream pixel fetcher
//  (pix_req/pix_x/pix_y -> pix_in) or replaced by a built-in test pattern for ADV7511 bring-up.

---
 rtl/adv_video_timing.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/adv_video_timing.sv
// Pixel-clock video timing generator with pass-through or built-in test-pattern pixel source.
// Three pipeline stages: request (pix_req/x/y), fetch (pix_in arrives), registered output.

module adv_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 12,
  parameter int YW       = 11
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    pattern_sel,
  input  logic [23:0]   solid_rgb,
  output logic          pix_req,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  input  logic [23:0]   pix_in,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [23:0]   data_out,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [XW-1:0] H_MAX   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] BAR_MAX = XW'(BAR_W - 1);
  localparam logic [YW-1:0] V_MAX   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PAT_PASS  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  // Raster counters and the bar tracker that replaces an x/BAR_W divider
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic [XW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  pattern_e      pat_q, pat_d;
  logic [23:0]   solid_q, solid_d;
  logic          active;

  logic          pix_req_q, pix_req_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic          s1_hs_q, s1_hs_d;
  logic          s1_vs_q, s1_vs_d;
  logic          s1_fs_q, s1_fs_d;
  logic [2:0]    s1_bar_q, s1_bar_d;

  logic          s2_act_q, s2_act_d;
  logic          s2_hs_q, s2_hs_d;
  logic          s2_vs_q, s2_vs_d;
  logic          s2_fs_q, s2_fs_d;
  logic          s2_pass_q, s2_pass_d;
  logic [23:0]   s2_rgb_q, s2_rgb_d;

  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [23:0]   data_q, data_d;
  logic          frame_start_q, frame_start_d;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    pat_d     = pat_q;
    solid_d   = solid_q;
    active    = (h_q < H_ACT) && (v_q < V_ACT);

    if (!enable) begin
      h_d       = '0;
      v_d       = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (h_q == H_MAX) begin
      h_d       = '0;
      bar_px_d  = '0;
      bar_idx_d = '0;
      v_d       = (v_q == V_MAX) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
      if (bar_px_q == BAR_MAX) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end

    // Pattern selection only changes on the edge that launches pixel (0,0)
    if (enable && (h_q == '0) && (v_q == '0)) begin
      pat_d   = pattern_e'(pattern_sel);
      solid_d = solid_rgb;
    end

    pix_req_d = enable && active;
    pix_x_d   = h_q;
    pix_y_d   = v_q;
    s1_hs_d   = enable && (h_q >= HS_BEG) && (h_q < HS_END);
    s1_vs_d   = enable && (v_q >= VS_BEG) && (v_q < VS_END);
    s1_fs_d   = enable && active && (h_q == '0) && (v_q == '0);
    s1_bar_d  = bar_idx_q;

    s2_act_d  = pix_req_q;
    s2_hs_d   = s1_hs_q;
    s2_vs_d   = s1_vs_q;
    s2_fs_d   = s1_fs_q;
    s2_pass_d = (pat_q == PAT_PASS);
    s2_rgb_d  = '0;
    case (pat_q)
      PAT_BARS:  s2_rgb_d = bar_rgb(s1_bar_q);
      PAT_GRID:  s2_rgb_d = ((pix_x_q[4:0] == 5'd0) || (pix_y_q[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: s2_rgb_d = solid_q;
      default:   s2_rgb_d = '0;
    endcase

    de_d          = s2_act_q;
    hsync_d       = s2_hs_q ? HS_POL : ~HS_POL;
    vsync_d       = s2_vs_q ? VS_POL : ~VS_POL;
    data_d        = !s2_act_q ? '0 : (s2_pass_q ? pix_in : s2_rgb_q);
    frame_start_d = s2_fs_q;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      bar_px_q      <= '0;
      bar_idx_q     <= '0;
      pat_q         <= PAT_PASS;
      solid_q       <= '0;
      pix_req_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_fs_q       <= 1'b0;
      s1_bar_q      <= '0;
      s2_act_q      <= 1'b0;
      s2_hs_q       <= 1'b0;
      s2_vs_q       <= 1'b0;
      s2_fs_q       <= 1'b0;
      s2_pass_q     <= 1'b1;
      s2_rgb_q      <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      data_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      bar_px_q      <= bar_px_d;
      bar_idx_q     <= bar_idx_d;
      pat_q         <= pat_d;
      solid_q       <= solid_d;
      pix_req_q     <= pix_req_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_fs_q       <= s1_fs_d;
      s1_bar_q      <= s1_bar_d;
      s2_act_q      <= s2_act_d;
      s2_hs_q       <= s2_hs_d;
      s2_vs_q       <= s2_vs_d;
      s2_fs_q       <= s2_fs_d;
      s2_pass_q     <= s2_pass_d;
      s2_rgb_q      <= s2_rgb_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_req     = pix_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign de_out      = de_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign data_out    = data_q;
  assign frame_start = frame_start_q;

endmodule
